display_page_arbiter: RTL and testbench

- Shares the single 8-digit hex seven-segment display between NUM_SRC status producers, such as MAC counters, CRC error counts and link state.
- Rotates through the valid sources round-robin, holding each one for a fixed dwell time.
- Supports a user "next page" button, a freeze control and per-source alert preemption.
- Output drives the 32-bit data input of the existing 8-hex display driver.

---
 rtl/display_pkg.sv | 24 ++
 rtl/display_page_arbiter_rr_next_pick.sv | 29 ++
 rtl/display_page_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_display_page_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the display page arbiter.
package display_pkg;

  localparam int DEF_NUM_SRC      = 4;
  localparam int SRC_IDX_W        = $clog2(DEF_NUM_SRC);
  localparam int DEF_HOLD_CYCLES  = 50_000_000;
  localparam int DEF_ALERT_CYCLES = 100_000_000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHOW  = 2'd1;
  localparam state_t ST_ALERT = 2'd2;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/display_page_arbiter_rr_next_pick.sv
// Round-robin picker: first valid index strictly after cur_i, wrapping,
// with cur_i itself as the last candidate.
module rr_next_pick
  import display_pkg::*;
#(
  parameter int N     = DEF_NUM_SRC,
  parameter int IDX_W = SRC_IDX_W
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] cur_i,
  output logic [IDX_W-1:0] next_o,
  output logic             found_o
);

  // Scan farthest-to-nearest so the nearest valid candidate wins.
  always_comb begin
    int idx;
    next_o  = cur_i;
    found_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(cur_i) + k) % N;
      if (valid_i[idx]) begin
        next_o  = IDX_W'(idx);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_page_arbiter.sv
// Time-shares the 8-digit hex display between NUM_SRC status sources with
// round-robin paging, a next-page button, freeze and alert preemption.
module display_page_arbiter
  import display_pkg::*;
#(
  parameter int NUM_SRC      = DEF_NUM_SRC,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int ALERT_CYCLES = DEF_ALERT_CYCLES,
  parameter int CNT_W        = 27,
  localparam int IDX_W       = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]    src_valid_i,
  input  logic [NUM_SRC-1:0]    alert_req_i,
  input  logic                  next_btn_i,
  input  logic                  freeze_i,
  output logic [31:0]           disp_data_o,
  output logic [IDX_W-1:0]      disp_src_o,
  output logic                  disp_blank_o,
  output logic                  alert_active_o
);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALERT_LD = CNT_W'(ALERT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]     saved_q, saved_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic                 blank_q, blank_d;
  logic                 alert_q, alert_d;
  logic [31:0]          data_q;

  logic [31:0]          src_arr [NUM_SRC];
  logic [NUM_SRC-1:0]   pend_all;
  logic [IDX_W-1:0]     alert_idx;
  logic [IDX_W-1:0]     pick_cur;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 take_alert;

  // Unpack the flat source bus into one word per source.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_arr[i] = src_data_i[32*i +: 32];
    end
  end

  // A same-cycle request counts as pending so preemption is immediate.
  assign pend_all  = pending_q | alert_req_i;
  assign alert_idx = IDX_W'(lowest_set(8'(pend_all)));

  // IDLE picks starting after the top index, i.e. the lowest valid source.
  always_comb begin
    case (state_q)
      ST_SHOW:  pick_cur = sel_q;
      ST_ALERT: pick_cur = saved_q;
      default:  pick_cur = IDX_W'(NUM_SRC - 1);
    endcase
  end

  rr_next_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid_i (src_valid_i),
    .cur_i   (pick_cur),
    .next_o  (pick_idx),
    .found_o (pick_found)
  );

  // Page selection state machine.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    saved_d    = saved_q;
    timer_d    = timer_q;
    blank_d    = blank_q;
    alert_d    = alert_q;
    pending_d  = pend_all;
    take_alert = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend_all) begin
          take_alert = 1'b1;
        end else if (pick_found) begin
          state_d = ST_SHOW;
          sel_d   = pick_idx;
          timer_d = HOLD_LD;
          blank_d = 1'b0;
        end else begin
          blank_d = 1'b1;
        end
      end
      ST_SHOW: begin
        if (|pend_all) begin
          take_alert = 1'b1;
          saved_d    = sel_q;
        end else if (!pick_found) begin
          state_d = ST_IDLE;
          blank_d = 1'b1;
        end else if (timer_q == '0 || next_btn_i || !src_valid_i[sel_q]) begin
          sel_d   = pick_idx;
          timer_d = HOLD_LD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      ST_ALERT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (|pend_all) begin
          take_alert = 1'b1;
        end else if (pick_found) begin
          state_d = ST_SHOW;
          sel_d   = src_valid_i[saved_q] ? saved_q : pick_idx;
          timer_d = HOLD_LD;
          alert_d = 1'b0;
          blank_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          alert_d = 1'b0;
          blank_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        alert_d = 1'b0;
        blank_d = 1'b1;
      end
    endcase
    if (take_alert) begin
      state_d   = ST_ALERT;
      sel_d     = alert_idx;
      pending_d = pend_all & ~({{(NUM_SRC-1){1'b0}}, 1'b1} << alert_idx);
      timer_d   = ALERT_LD;
      alert_d   = 1'b1;
      blank_d   = 1'b0;
    end else begin
      pending_d = pend_all;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      saved_q   <= '0;
      timer_q   <= '0;
      pending_q <= '0;
      blank_q   <= 1'b1;
      alert_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      saved_q   <= saved_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      blank_q   <= blank_d;
      alert_q   <= alert_d;
    end
  end

  // Display word follows the registered selection one cycle later; freeze holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (!freeze_i) begin
      data_q <= blank_q ? 32'd0 : src_arr[sel_q];
    end else begin
      data_q <= data_q;
    end
  end

  assign disp_data_o    = data_q;
  assign disp_src_o     = sel_q;
  assign disp_blank_o   = blank_q;
  assign alert_active_o = alert_q;

endmodule

// File: tb/tb_display_page_arbiter.sv
// Directed, table-driven bench for display_page_arbiter (4 sources, short dwell times).
module tb_display_page_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic [3:0]   alert_req;
  logic         next_btn;
  logic         freeze;
  logic [31:0]  disp_data;
  logic [1:0]   disp_src;
  logic         disp_blank;
  logic         alert_active;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0]  valid;
    logic [3:0]  alert;
    logic        nxt;
    logic [1:0]  src;
    logic        blank;
    logic        alrt;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  display_page_arbiter #(
    .NUM_SRC      (4),
    .HOLD_CYCLES  (4),
    .ALERT_CYCLES (6),
    .CNT_W        (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .src_data_i     (src_data),
    .src_valid_i    (src_valid),
    .alert_req_i    (alert_req),
    .next_btn_i     (next_btn),
    .freeze_i       (freeze),
    .disp_data_o    (disp_data),
    .disp_src_o     (disp_src),
    .disp_blank_o   (disp_blank),
    .alert_active_o (alert_active)
  );

  function automatic logic [31:0] da(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s, input logic b,
                         input logic a, input logic [31:0] d);
    chk({tag, " disp_src"}, 32'(disp_src), 32'(s));
    chk({tag, " disp_blank"}, 32'(disp_blank), 32'(b));
    chk({tag, " alert_active"}, 32'(alert_active), 32'(a));
    chk({tag, " disp_data"}, disp_data, d);
  endtask

  task automatic add(input int n, input logic [3:0] v, input logic [3:0] al, input logic nx,
                     input logic [1:0] s, input logic b, input logic a, input logic [31:0] d);
    vec_t e;
    e.valid = v; e.alert = al; e.nxt = nx;
    e.src = s; e.blank = b; e.alrt = a; e.data = d;
    for (int k = 0; k < n; k++) vecs.push_back(e);
  endtask

  initial begin
    logic [3:0] B;
    logic [3:0] F;
    B = 4'b1011;
    F = 4'b1111;
    rst = 1'b1; src_valid = 4'd0; alert_req = 4'd0; next_btn = 1'b0; freeze = 1'b0;
    for (int i = 0; i < 4; i++) src_data[32*i +: 32] = da(i);

    // Rotation over 0,1,3 then idle.
    add(1, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    add(3, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(0));
    add(1, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(0));
    add(3, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(1));
    add(1, B, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0, da(1));
    add(3, B, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0, da(3));
    add(1, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(3));
    add(1, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(0));
    add(1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, da(0));
    add(1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0);
    // Next button and invalidated source.
    add(1, F, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    add(3, F, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(0));
    add(1, F, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(0));
    add(1, F, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(1));
    add(1, F, 4'd0, 1'b1, 2'd2, 1'b0, 1'b0, da(1));
    add(3, F, 4'd0, 1'b0, 2'd2, 1'b0, 1'b0, da(2));
    add(1, F, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0, da(2));
    add(1, F, 4'd0, 1'b1, 2'd0, 1'b0, 1'b0, da(3));
    add(1, F, 4'd0, 1'b1, 2'd1, 1'b0, 1'b0, da(0));
    add(1, F, 4'd0, 1'b1, 2'd2, 1'b0, 1'b0, da(1));
    add(1, B, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0, da(2));
    add(3, B, 4'd0, 1'b0, 2'd3, 1'b0, 1'b0, da(3));
    add(1, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(3));
    add(1, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(0));
    // Alert preemption and resume on saved source.
    add(1, B, 4'b0100, 1'b0, 2'd2, 1'b0, 1'b1, da(0));
    add(5, B, 4'd0, 1'b0, 2'd2, 1'b0, 1'b1, da(2));
    add(1, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(2));
    add(3, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0, da(0));
    add(1, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(0));
    add(1, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(1));
    // Queued alerts.
    add(1, B, 4'b1000, 1'b0, 2'd3, 1'b0, 1'b1, da(1));
    add(1, B, 4'b0010, 1'b0, 2'd3, 1'b0, 1'b1, da(3));
    add(4, B, 4'd0, 1'b0, 2'd3, 1'b0, 1'b1, da(3));
    add(1, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b1, da(3));
    add(5, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b1, da(1));
    add(2, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(1));
    // Alert with same-cycle next_btn, then next_btn during alert.
    add(1, B, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1, da(1));
    add(1, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, da(0));
    add(1, B, 4'd0, 1'b1, 2'd0, 1'b0, 1'b1, da(0));
    add(3, B, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1, da(0));
    add(1, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(0));
    add(1, B, 4'd0, 1'b0, 2'd1, 1'b0, 1'b0, da(1));

    step();
    step();
    chk_out("reset", 2'd0, 1'b1, 1'b0, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      src_valid = vecs[k].valid;
      alert_req = vecs[k].alert;
      next_btn  = vecs[k].nxt;
      step();
      chk_out($sformatf("v%0d", k + 1), vecs[k].src, vecs[k].blank, vecs[k].alrt, vecs[k].data);
    end
    alert_req = 4'd0;
    next_btn  = 1'b0;

    // Freeze holds the word while the page keeps rotating.
    freeze = 1'b1;
    src_data[63:32] = 32'h1234_5678;
    step();
    chk_out("frz1", 2'd1, 1'b0, 1'b0, da(1));
    step();
    chk_out("frz2", 2'd1, 1'b0, 1'b0, da(1));
    step();
    chk_out("frz3", 2'd3, 1'b0, 1'b0, da(1));
    freeze = 1'b0;
    src_data[63:32] = da(1);
    step();
    chk_out("unfrz", 2'd3, 1'b0, 1'b0, da(3));

    // Asynchronous reset in the middle of an alert with a queued request.
    alert_req = 4'b0010;
    step();
    alert_req = 4'b0001;
    step();
    alert_req = 4'd0;
    step();
    chk_out("alert_pre_rst", 2'd1, 1'b0, 1'b1, da(1));
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 2'd0, 1'b1, 1'b0, 32'd0);
    src_valid = 4'd0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_out($sformatf("post_rst%0d", k), 2'd0, 1'b1, 1'b0, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
